// File: rtl/iter_comp_if.sv
// Handshake and operand bundle for the iterative magnitude comparator.
// The requester drives start/operands; the comparator returns busy/done and one-hot flags.
interface iter_comp_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, gt, eq, lt
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, gt, eq, lt
  );
endinterface

// File: rtl/iter_comp.sv
// Iterative MSB-first magnitude comparator, CHUNK bits per clock with early exit
// on the first differing chunk; signed mode uses offset binary so one unsigned compare serves both.
module iter_comp #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic       clk,
  input  logic       rst,
  iter_comp_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic             accept;

  // Operands shift left each step, so the chunk under test always sits at the top.
  assign a_chunk = a_q[WIDTH-1 -: CHUNK];
  assign b_chunk = b_q[WIDTH-1 -: CHUNK];
  assign accept  = bus.start && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;

    case (state_q)
      RUN: begin
        if (a_chunk != b_chunk) begin
          gt_d    = (a_chunk > b_chunk);
          lt_d    = (a_chunk < b_chunk);
          state_d = DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDXW'(1);
          a_d   = a_q << CHUNK;
          b_d   = b_q << CHUNK;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = state_q;
    endcase

    // Acceptance in DONE takes precedence so back-to-back compares lose no cycle.
    if (accept) begin
      state_d         = RUN;
      a_d             = bus.a;
      b_d             = bus.b;
      a_d[WIDTH-1]    = bus.a[WIDTH-1] ^ bus.signed_mode;
      b_d[WIDTH-1]    = bus.b[WIDTH-1] ^ bus.signed_mode;
      idx_d           = LAST_IDX;
      gt_d            = 1'b0;
      eq_d            = 1'b0;
      lt_d            = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.gt   = gt_q;
  assign bus.eq   = eq_q;
  assign bus.lt   = lt_q;
endmodule

// File: tb/tb_iter_comp.sv
// Self-checking bench for iter_comp in three configurations (16/4, 4/1, 4/4):
// directed handshake cases, random 16-bit compares and exhaustive 4-bit sweeps against an arithmetic model.
module tb_iter_comp;
  logic clk = 1'b0;
  logic rst;
  int   passCount  = 0;
  int   failCount  = 0;
  int   totalCount = 0;

  always #5 clk = ~clk;

  iter_comp_if #(.WIDTH(16)) ifA ();
  iter_comp_if #(.WIDTH(4))  ifB ();
  iter_comp_if #(.WIDTH(4))  ifC ();

  iter_comp #(.WIDTH(16), .CHUNK(4)) dutA (.clk(clk), .rst(rst), .bus(ifA));
  iter_comp #(.WIDTH(4),  .CHUNK(1)) dutB (.clk(clk), .rst(rst), .bus(ifB));
  iter_comp #(.WIDTH(4),  .CHUNK(4)) dutC (.clk(clk), .rst(rst), .bus(ifC));

  function automatic int widthOf(input int sel);
    return (sel == 0) ? 16 : 4;
  endfunction

  function automatic int chunkOf(input int sel);
    return (sel == 1) ? 1 : 4;
  endfunction

  // Reference: compare as plain integers, signed when requested.
  function automatic logic [2:0] refFlags(input int w, input int av, input int bv, input logic sm);
    int sa;
    int sb;
    sa = av;
    sb = bv;
    if (sm && av >= (1 << (w - 1))) sa = av - (1 << w);
    if (sm && bv >= (1 << (w - 1))) sb = bv - (1 << w);
    if (sa > sb) return 3'b100;
    if (sa == sb) return 3'b010;
    return 3'b001;
  endfunction

  // Reference latency: number of MSB chunks needed to see the first difference.
  function automatic int refLatency(input int w, input int c, input int av, input int bv);
    for (int k = 1; k <= w / c; k++) begin
      if ((av >> (w - k * c)) != (bv >> (w - k * c))) return k;
    end
    return w / c;
  endfunction

  task automatic driveInputs(input int sel, input logic st, input logic sm,
                             input logic [15:0] a, input logic [15:0] b);
    case (sel)
      0: begin ifA.start = st; ifA.signed_mode = sm; ifA.a = a;      ifA.b = b;      end
      1: begin ifB.start = st; ifB.signed_mode = sm; ifB.a = a[3:0]; ifB.b = b[3:0]; end
      default: begin ifC.start = st; ifC.signed_mode = sm; ifC.a = a[3:0]; ifC.b = b[3:0]; end
    endcase
  endtask

  function automatic logic [4:0] readStatus(input int sel);
    case (sel)
      0:       return {ifA.busy, ifA.done, ifA.gt, ifA.eq, ifA.lt};
      1:       return {ifB.busy, ifB.done, ifB.gt, ifB.eq, ifB.lt};
      default: return {ifC.busy, ifC.done, ifC.gt, ifC.eq, ifC.lt};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Pulses start for one edge (edge 0); returns #1 after that edge.
  task automatic applyStimulus(input int sel, input logic [15:0] a, input logic [15:0] b, input logic sm);
    @(negedge clk);
    driveInputs(sel, 1'b1, sm, a, b);
    @(posedge clk);
    #1;
    driveInputs(sel, 1'b0, sm, a, b);
  endtask

  // Counts edges until done is seen; -1 if the budget runs out.
  task automatic waitDone(input int sel, output int lat);
    logic [4:0] st;
    bit found;
    lat   = -1;
    found = 1'b0;
    for (int i = 1; i <= 40 && !found; i++) begin
      @(posedge clk);
      #1;
      st = readStatus(sel);
      if (st[3]) begin
        lat   = i;
        found = 1'b1;
      end
    end
  endtask

  task automatic runCompare(input int sel, input logic [15:0] a, input logic [15:0] b,
                            input logic sm, input string tag);
    logic [2:0] expFlags;
    int expLat;
    int lat;
    expFlags = refFlags(widthOf(sel), int'(a), int'(b), sm);
    expLat   = refLatency(widthOf(sel), chunkOf(sel), int'(a), int'(b));
    applyStimulus(sel, a, b, sm);
    checkOutput({tag, " accept"}, 32'(readStatus(sel)), 32'(5'b10000));
    waitDone(sel, lat);
    checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, " flags"}, 32'(readStatus(sel)), 32'({2'b01, expFlags}));
  endtask

  initial begin
    int lat;
    logic [15:0] ra;
    logic [15:0] rb;
    logic rs;

    rst = 1'b1;
    for (int s = 0; s < 3; s++) driveInputs(s, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) checkOutput($sformatf("reset state dut%0d", s), 32'(readStatus(s)), 32'h0);
    rst = 1'b0;

    runCompare(0, 16'h1234, 16'h1234, 1'b0, "eq 1234");
    runCompare(0, 16'h8000, 16'h7FFF, 1'b0, "unsigned 8000>7FFF");
    runCompare(0, 16'h8000, 16'h7FFF, 1'b1, "signed 8000<7FFF");
    runCompare(0, 16'h1235, 16'h1234, 1'b0, "gt last chunk");
    runCompare(0, 16'h1134, 16'h1234, 1'b0, "lt second chunk");

    // start re-pulsed with new operands while busy must be ignored
    repeat (2) @(posedge clk);
    applyStimulus(0, 16'h1235, 16'h1234, 1'b0);
    driveInputs(0, 1'b1, 1'b1, 16'h0000, 16'hFFFF);
    repeat (2) @(posedge clk);
    #1;
    driveInputs(0, 1'b0, 1'b1, 16'h0000, 16'hFFFF);
    waitDone(0, lat);
    checkOutput("busy ignore latency", 32'(lat), 32'd2);
    checkOutput("busy ignore flags", 32'(readStatus(0)), 32'(5'b01100));

    // start presented during the done cycle is a new compare
    driveInputs(0, 1'b1, 1'b0, 16'h1134, 16'h1234);
    @(posedge clk);
    #1;
    driveInputs(0, 1'b0, 1'b0, 16'h1134, 16'h1234);
    checkOutput("done-cycle accept", 32'(readStatus(0)), 32'(5'b10000));
    waitDone(0, lat);
    checkOutput("done-cycle latency", 32'(lat), 32'd2);
    checkOutput("done-cycle flags", 32'(readStatus(0)), 32'(5'b01001));

    // reset in the middle of a compare
    applyStimulus(0, 16'h1234, 16'h1234, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid-run reset", 32'(readStatus(0)), 32'h0);
    rst = 1'b0;
    runCompare(0, 16'hABCD, 16'hABCC, 1'b1, "after reset");

    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      if ($urandom_range(0, 3) == 0) rb = ra;
      else if ($urandom_range(0, 2) == 0) rb = {ra[15:8], rb[7:0]};
      repeat ($urandom_range(0, 2)) @(posedge clk);
      runCompare(0, ra, rb, rs, $sformatf("rand%0d %h %h s%0d", i, ra, rb, rs));
    end

    for (int s = 1; s < 3; s++) begin
      for (int m = 0; m < 2; m++) begin
        for (int x = 0; x < 16; x++) begin
          for (int y = 0; y < 16; y++) begin
            runCompare(s, 16'(x), 16'(y), 1'(m), $sformatf("dut%0d m%0d %0h vs %0h", s, m, x, y));
          end
        end
      end
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end
endmodule
